nsu_flit_reorder: RTL and testbench
===================================

// Module: nsu_flit_reorder
// PURPOSE
//  Ingress stage of the NoC slave unit, directly upstream of the NSU depacketizer.
//  Accepts NPP flits from the router, parses head/tail flits and steers data flits into per-VC FIFOs by one-hot PACK_ORDER.
//  Publishes the packet header fields plus a one-cycle nocpack_done at each tail; the depacketizer drains the VC FIFOs via rd_en.
// PARAMETERS
//  DATA_WIDTH      128    flit / data width
//  AXI_ADDR_WIDTH  32     AXI_ADDR and RE_PACK field width
//  ID_WIDTH        4      Source_ID / Dest_ID width
//  VIRTUAL_CH_NUM  8      VC count; PACK_ORDER/PACK_NUM one-hot width
//  VC_FIFO_DEPTH   16     data flits per VC FIFO (power of 2)
//  NODE_ID         0      this NSU's Dest_ID
//  HEAD_CODE_H/E   8'hA5/8'h5A  head markers, flit[127:120] / flit[7:0]
//  TAIL_CODE_H/E   8'hC3/8'h3C  tail markers, same positions
// PORTS
//  noc_clk       in   1      single clock
//  noc_rst       in   1      asynchronous, active-high reset
//  flit_in       in   DATA_WIDTH  router flit
//  flit_valid    in   1      flit_in valid
//  flit_ready    out  1      flit accepted when valid & ready
//  axi_addr      out  AXI_ADDR_WIDTH  head AXI_ADDR
//  axi_len       out  8      head AXI_LEN
//  axi_type      out  3      head TYPE
//  source_id     out  ID_WIDTH  head Source_ID
//  re_pack       out  AXI_ADDR_WIDTH  tail RE_PACK
//  pack_num      out  VIRTUAL_CH_NUM  tail PACK_NUM (one-hot, last order)
//  nocpack_done  out  1      one-cycle pulse: packet complete
//  rd_en         in   VIRTUAL_CH_NUM  one-hot VC FIFO pop
//  data_out      out  DATA_WIDTH  popped data flit
//  empty_vc      out  VIRTUAL_CH_NUM  per-VC FIFO empty
//  nsu_busy      in   1      depacketizer busy; blocks new heads
//  err_cnt       out  8      saturating protocol-error count
// BEHAVIOUR
//  Field map, MSB down from bit 119: Source_ID[119:116], Dest_ID[115:112], TYPE[111:109], ORDER/NUM[108:101], LEN[100:93], ADDR/RE_PACK[92:61].
//  Head = H marker AND E marker both match HEAD codes; tail likewise. Data flits are any other flit in S_DATA.
//  FSM: S_IDLE -> S_DATA on accepted head (Dest_ID==NODE_ID); -> S_DROP on head with other Dest_ID.
//   S_DATA: data flit written to VC f(PACK_ORDER); tail -> S_IDLE. S_DROP: flits consumed, nothing written; tail -> S_IDLE.
//  Header fields go into staging regs at head; axi_addr/len/type/source_id, re_pack, pack_num update together at tail accept, cycle t+1.
//   Fields hold until the next tail, because the depacketizer samples them up to 3 cycles later.
//  nocpack_done: high exactly in cycle t+1 after tail accept in S_DATA; never for dropped packets.
//  TYPE 3'b010 (read request) is head+tail only, with no data written; it is legal.
//  flit_ready = 0 in S_IDLE while nsu_busy=1, and in S_DATA while the target VC FIFO is full; otherwise 1.
//  VC FIFO: synchronous read; rd_en[k] at cycle t -> data_out valid at t+1, held until the next pop. rd_en on an empty VC is ignored.
//  Simultaneous push+pop on the same VC in one cycle: both occur and the count is unchanged. A full FIFO accepts a push only with a same-cycle pop.
//  empty_vc is registered from the count and is low in the cycle after the first write.
//  Errors increment err_cnt, which saturates at 8'hFF:
//   non-head flit in S_IDLE: dropped;
//   PACK_ORDER not one-hot: packet goes to S_DROP;
//   head in S_DATA: the previous packet is abandoned with no done pulse, its written flits are retained, and the new head is processed.
//  Reset values: flit_ready 0, all field outputs 0, nocpack_done 0, data_out 0, empty_vc all 1, err_cnt 0, FSM S_IDLE, FIFOs flushed.
//   Reset mid-packet discards all state; no done pulse follows.
//  flit_ready rises in the first cycle after reset deassert.
// TESTING
//  Write packet (head TYPE=100, ORDER=8'h04, ADDR=32'h1000, LEN=3) + 4 data + tail (NUM=8'h04) -> VC2 holds 4 flits; done pulse 1 cycle after tail; axi_addr=32'h1000.
//  Read request (TYPE=010, head+tail) -> done pulse, all empty_vc=8'hFF, no data written.
//  Fill VC0 with 16 flits, send a 17th -> flit_ready low until rd_en[0]; then accepted; the pop returns the first flit at t+1.
//  Dest_ID=4'h3 with NODE_ID=0 -> whole packet consumed, no done, FIFOs untouched, err_cnt 0.
//  Data flit in S_IDLE, and ORDER=8'h06 -> err_cnt increments to 2; nothing written.
//  Assert noc_rst after 2 of 4 data flits -> empty_vc=8'hFF, no done; next packet processed normally.

Source files
------------

// File: rtl/nsu_flit_reorder.sv
// Generic VC FIFO: power-of-2 depth with a registered read port and a registered empty flag.
// Latency: pop at cycle t presents the head entry on pop_dat at t+1, held until the next pop.
// Backpressure: a push is taken when not full, or when full together with a same-cycle pop; a pop on empty is ignored.
module nsu_flit_reorder_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic             noc_clk,
    input  logic             noc_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_nxt;
    logic             do_push;
    logic             do_pop;

    // Qualify requests; a full FIFO makes room only when the head leaves in the same cycle.
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != FULL_CNT) || do_pop);
        cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    assign full = (cnt == FULL_CNT);

    // Pointers, occupancy, registered empty flag and the held read data.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            empty   <= 1'b1;
            pop_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                pop_dat <= mem[rd_ptr];
            end
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
        end
    end

    // Storage array; flushing is done through the pointers so the array itself has no reset.
    always_ff @(posedge noc_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end
endmodule

// NSU ingress: parses head/tail flits, steers data flits into per-VC FIFOs, publishes header fields at tail.
// Latency: fields and nocpack_done one cycle after tail accept; VC pop data one cycle after rd_en.
// Backpressure: flit_ready low in idle while nsu_busy, and in a packet while its target VC FIFO is full without a pop.
module nsu_flit_reorder #(
    parameter int         DATA_WIDTH     = 128,
    parameter int         AXI_ADDR_WIDTH = 32,
    parameter int         ID_WIDTH       = 4,
    parameter int         VIRTUAL_CH_NUM = 8,
    parameter int         VC_FIFO_DEPTH  = 16,
    parameter int         NODE_ID        = 0,
    parameter logic [7:0] HEAD_CODE_H    = 8'hA5,
    parameter logic [7:0] HEAD_CODE_E    = 8'h5A,
    parameter logic [7:0] TAIL_CODE_H    = 8'hC3,
    parameter logic [7:0] TAIL_CODE_E    = 8'h3C
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic [DATA_WIDTH-1:0]     flit_in,
    input  logic                      flit_valid,
    output logic                      flit_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    output logic [7:0]                axi_len,
    output logic [2:0]                axi_type,
    output logic [ID_WIDTH-1:0]       source_id,
    output logic [AXI_ADDR_WIDTH-1:0] re_pack,
    output logic [VIRTUAL_CH_NUM-1:0] pack_num,
    output logic                      nocpack_done,
    input  logic [VIRTUAL_CH_NUM-1:0] rd_en,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [VIRTUAL_CH_NUM-1:0] empty_vc,
    input  logic                      nsu_busy,
    output logic [7:0]                err_cnt
);
    localparam int VC_W   = (VIRTUAL_CH_NUM > 1) ? $clog2(VIRTUAL_CH_NUM) : 1;
    localparam int RSVD_W = DATA_WIDTH - 8 - 2*ID_WIDTH - 3 - 8 - 8 - AXI_ADDR_WIDTH - 8;
    localparam logic [7:0] ORD_MASK = 8'((1 << VIRTUAL_CH_NUM) - 1);

    // Flit layout; ORDER/NUM and ADDR/RE_PACK share positions between head and tail.
    typedef struct packed {
        logic [7:0]                mark_h;
        logic [ID_WIDTH-1:0]       src_id;
        logic [ID_WIDTH-1:0]       dst_id;
        logic [2:0]                pkt_type;
        logic [7:0]                order;
        logic [7:0]                len;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [RSVD_W-1:0]         rsvd;
        logic [7:0]                mark_e;
    } hdr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DROP
    } state_t;

    state_t                    state;
    hdr_t                      hdr;
    logic                      is_head;
    logic                      is_tail;
    logic                      is_data;
    logic                      dst_ok;
    logic                      ord_ok;
    logic                      flit_acc;
    logic                      err_hit;
    logic                      live;
    logic [VC_W-1:0]           hdr_vc;
    logic [VC_W-1:0]           stg_vc;
    logic [VC_W-1:0]           pop_idx;
    logic [VC_W-1:0]           pop_sel;
    logic                      pop_any;
    logic [VIRTUAL_CH_NUM-1:0] vc_push;
    logic [VIRTUAL_CH_NUM-1:0] vc_pop;
    logic [VIRTUAL_CH_NUM-1:0] vc_full;
    logic [DATA_WIDTH-1:0]     vc_pop_dat [VIRTUAL_CH_NUM];
    logic [AXI_ADDR_WIDTH-1:0] stg_addr;
    logic [7:0]                stg_len;
    logic [2:0]                stg_type;
    logic [ID_WIDTH-1:0]       stg_src;

    assign hdr = hdr_t'(flit_in);

    // Flit classification and one-hot ORDER decode to a VC index.
    always_comb begin
        is_head = (hdr.mark_h == HEAD_CODE_H) && (hdr.mark_e == HEAD_CODE_E);
        is_tail = (hdr.mark_h == TAIL_CODE_H) && (hdr.mark_e == TAIL_CODE_E);
        is_data = !is_head && !is_tail;
        dst_ok  = (hdr.dst_id == ID_WIDTH'(NODE_ID));
        ord_ok  = $onehot(hdr.order) && ((hdr.order & ~ORD_MASK) == 8'h00);
        hdr_vc  = '0;
        for (int i = 0; i < VIRTUAL_CH_NUM; i++) begin
            if (hdr.order[i]) begin
                hdr_vc = VC_W'(i);
            end
        end
    end

    // Pop arbitration: rd_en is expected one-hot; the lowest non-empty requested VC wins otherwise.
    always_comb begin
        pop_any = 1'b0;
        pop_idx = '0;
        vc_pop  = '0;
        for (int i = VIRTUAL_CH_NUM - 1; i >= 0; i--) begin
            if (rd_en[i] && !empty_vc[i]) begin
                pop_any = 1'b1;
                pop_idx = VC_W'(i);
            end
        end
        if (pop_any) begin
            vc_pop[pop_idx] = 1'b1;
        end
    end

    // Ready: gated off until the first cycle after reset, then by busy in idle or target-VC room in a packet.
    always_comb begin
        flit_ready = 1'b0;
        if (live) begin
            case (state)
                S_IDLE:  flit_ready = !nsu_busy;
                S_DATA:  flit_ready = !vc_full[stg_vc] || vc_pop[stg_vc];
                default: flit_ready = 1'b1;
            endcase
        end
        flit_acc = flit_valid && flit_ready;
    end

    // Data flits of an accepted packet go to the VC named by its head; errors are one event per flit.
    always_comb begin
        vc_push = '0;
        if (flit_acc && (state == S_DATA) && is_data) begin
            vc_push[stg_vc] = 1'b1;
        end
        err_hit = flit_acc && (((state == S_IDLE) && !is_head) ||
                               ((state == S_DATA) && is_head) ||
                               ((state != S_DROP) && is_head && dst_ok && !ord_ok));
    end

    for (genvar g = 0; g < VIRTUAL_CH_NUM; g++) begin : g_vc
        nsu_flit_reorder_fifo #(
            .WIDTH(DATA_WIDTH),
            .DEPTH(VC_FIFO_DEPTH)
        ) u_fifo (
            .noc_clk (noc_clk),
            .noc_rst (noc_rst),
            .push    (vc_push[g]),
            .push_dat(hdr),
            .pop     (vc_pop[g]),
            .pop_dat (vc_pop_dat[g]),
            .full    (vc_full[g]),
            .empty   (empty_vc[g])
        );
    end

    // data_out follows whichever VC was popped last, so it holds across idle or empty-VC reads.
    assign data_out = vc_pop_dat[pop_sel];

    // Post-reset ready enable and last-popped VC select.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            live    <= 1'b0;
            pop_sel <= '0;
        end else begin
            live <= 1'b1;
            if (pop_any) begin
                pop_sel <= pop_idx;
            end
        end
    end

    // Saturating protocol-error counter.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            err_cnt <= 8'h00;
        end else if (err_hit && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // Packet FSM: staging at head, published fields and done pulse at tail; a head mid-packet restarts.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state        <= S_IDLE;
            stg_vc       <= '0;
            stg_addr     <= '0;
            stg_len      <= '0;
            stg_type     <= '0;
            stg_src      <= '0;
            axi_addr     <= '0;
            axi_len      <= '0;
            axi_type     <= '0;
            source_id    <= '0;
            re_pack      <= '0;
            pack_num     <= '0;
            nocpack_done <= 1'b0;
        end else begin
            nocpack_done <= 1'b0;
            if (flit_acc) begin
                if (is_head) begin
                    if (state != S_DROP) begin
                        if (!dst_ok || !ord_ok) begin
                            state <= S_DROP;
                        end else begin
                            state    <= S_DATA;
                            stg_vc   <= hdr_vc;
                            stg_addr <= hdr.addr;
                            stg_len  <= hdr.len;
                            stg_type <= hdr.pkt_type;
                            stg_src  <= hdr.src_id;
                        end
                    end
                end else if (is_tail && (state != S_IDLE)) begin
                    if (state == S_DATA) begin
                        axi_addr     <= stg_addr;
                        axi_len      <= stg_len;
                        axi_type     <= stg_type;
                        source_id    <= stg_src;
                        re_pack      <= hdr.addr;
                        pack_num     <= hdr.order[VIRTUAL_CH_NUM-1:0];
                        nocpack_done <= 1'b1;
                    end
                    state <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_nsu_flit_reorder.sv
// Randomised and directed bench for nsu_flit_reorder against a packet-level reference model.
// Inputs change #1 after an edge; outputs are sampled #1 after the capturing posedge.
// Every flit waits for flit_ready with a cycle bound so a stuck DUT still reaches the summary.
module tb_nsu_flit_reorder;
    logic         noc_clk = 1'b0;
    logic         noc_rst = 1'b0;
    logic [127:0] flit_in = '0;
    logic         flit_valid = 1'b0;
    logic         flit_ready;
    logic [31:0]  axi_addr;
    logic [7:0]   axi_len;
    logic [2:0]   axi_type;
    logic [3:0]   source_id;
    logic [31:0]  re_pack;
    logic [7:0]   pack_num;
    logic         nocpack_done;
    logic [7:0]   rd_en = '0;
    logic [127:0] data_out;
    logic [7:0]   empty_vc;
    logic         nsu_busy = 1'b0;
    logic [7:0]   err_cnt;

    nsu_flit_reorder dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .flit_in(flit_in), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .axi_addr(axi_addr), .axi_len(axi_len), .axi_type(axi_type),
        .source_id(source_id), .re_pack(re_pack), .pack_num(pack_num), .nocpack_done(nocpack_done),
        .rd_en(rd_en), .data_out(data_out), .empty_vc(empty_vc), .nsu_busy(nsu_busy), .err_cnt(err_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: per-VC queues plus the packet context the protocol implies.
    logic [127:0] mq [8][$];
    int           m_state;      // 0 idle, 1 inside a packet for this node, 2 discarding
    int           m_vc;
    int           exp_err;
    logic [127:0] last_pop;
    logic [31:0]  s_addr, e_addr, e_rp;
    logic [7:0]   s_len, e_len, e_num;
    logic [2:0]   s_type, e_type;
    logic [3:0]   s_src, e_src;
    logic [127:0] fd [17];
    bit           abandoned;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [127:0] mk_head(input logic [3:0] src, input logic [3:0] dst, input logic [2:0] typ,
                                             input logic [7:0] ord, input logic [7:0] len, input logic [31:0] addr);
        logic [127:0] f;
        f = '0;
        f[127:120] = 8'hA5; f[7:0] = 8'h5A;
        f[119:116] = src; f[115:112] = dst; f[111:109] = typ;
        f[108:101] = ord; f[100:93] = len; f[92:61] = addr;
        return f;
    endfunction

    function automatic logic [127:0] mk_tail(input logic [7:0] num, input logic [31:0] rp);
        logic [127:0] f;
        f = '0;
        f[127:120] = 8'hC3; f[7:0] = 8'h3C;
        f[108:101] = num; f[92:61] = rp;
        return f;
    endfunction

    function automatic logic [127:0] rand_data();
        logic [127:0] f;
        f = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (f[127:120] == 8'hA5 || f[127:120] == 8'hC3) f[127:120] = 8'h77;
        return f;
    endfunction

    function automatic logic [7:0] m_empty();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = (mq[k].size() == 0);
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) mq[k].delete();
        m_state = 0; m_vc = 0; exp_err = 0; last_pop = '0;
        {s_addr, s_len, s_type, s_src} = '0;
        {e_addr, e_len, e_type, e_src, e_rp, e_num} = '0;
    endtask

    function automatic void err_up();
        if (exp_err < 255) exp_err++;
    endfunction

    function automatic void model_head(input logic [127:0] f);
        if (f[115:112] != 4'h0) m_state = 2;
        else if (!$onehot(f[108:101])) begin err_up(); m_state = 2; end
        else begin
            s_addr = f[92:61]; s_len = f[100:93]; s_type = f[111:109]; s_src = f[119:116];
            m_vc = $clog2(f[108:101]); m_state = 1;
        end
    endfunction

    // Apply one accepted flit to the model and compare the cycle-after-accept outputs.
    task automatic model_accept(input logic [127:0] f);
        bit hd, tl, exp_done;
        hd = (f[127:120] == 8'hA5) && (f[7:0] == 8'h5A);
        tl = (f[127:120] == 8'hC3) && (f[7:0] == 8'h3C);
        exp_done = 0;
        case (m_state)
            0: if (hd) model_head(f); else err_up();
            1: begin
                if (hd) begin err_up(); model_head(f); end
                else if (tl) begin
                    {e_addr, e_len, e_type, e_src} = {s_addr, s_len, s_type, s_src};
                    e_rp = f[92:61]; e_num = f[108:101];
                    exp_done = 1; m_state = 0;
                end else mq[m_vc].push_back(f);
            end
            default: if (tl) m_state = 0;
        endcase
        chk("done", nocpack_done, exp_done);
        chk("err_cnt", err_cnt, exp_err);
        chk("empty_vc", empty_vc, m_empty());
        if (tl) chk("fields", {axi_addr, axi_len, axi_type, source_id, re_pack, pack_num},
                    {e_addr, e_len, e_type, e_src, e_rp, e_num});
    endtask

    task automatic send(input logic [127:0] f);
        int n;
        n = 0;
        @(negedge noc_clk); #1;
        flit_in = f; flit_valid = 1'b1;
        while (!flit_ready && n < 300) begin @(negedge noc_clk); #1; n++; end
        if (!flit_ready) begin
            chk("ready_timeout", 1'b0, 1'b1);
            flit_valid = 1'b0;
            return;
        end
        @(posedge noc_clk); #1;
        flit_valid = 1'b0;
        model_accept(f);
    endtask

    task automatic pop(input int k);
        @(negedge noc_clk);
        rd_en = 8'(1 << k);
        @(posedge noc_clk); #1;
        rd_en = '0;
        if (mq[k].size() != 0) last_pop = mq[k].pop_front();
        chk("pop_data", data_out, last_pop);
    endtask

    task automatic do_reset();
        @(negedge noc_clk);
        noc_rst = 1'b1; flit_valid = 1'b0; rd_en = '0;
        #1;
        model_clear();
        chk("rst_ready", flit_ready, 1'b0);
        chk("rst_fields", {axi_addr, axi_len, axi_type, source_id, re_pack, pack_num}, '0);
        chk("rst_done", nocpack_done, 1'b0);
        chk("rst_data_out", data_out, '0);
        chk("rst_empty", empty_vc, 8'hFF);
        chk("rst_err", err_cnt, 8'h00);
        repeat (2) @(negedge noc_clk);
        noc_rst = 1'b0;
        @(posedge noc_clk); #1;
        chk("ready_after_rst", flit_ready, 1'b1);
        chk("no_done_after_rst", nocpack_done, 1'b0);
    endtask

    initial begin
        do_reset();

        // Write packet into VC2.
        send(mk_head(4'h5, 4'h0, 3'b100, 8'h04, 8'd3, 32'h1000));
        repeat (4) send(rand_data());
        send(mk_tail(8'h04, 32'h2000));
        chk("wr_axi_addr", axi_addr, 32'h1000);
        chk("wr_vc2_loaded", empty_vc, 8'hFB);
        @(posedge noc_clk); #1;
        chk("done_one_cycle", nocpack_done, 1'b0);
        repeat (5) pop(2);          // fifth pop hits an empty VC: data_out must hold
        chk("wr_drained", empty_vc, 8'hFF);

        // Read request: head + tail only.
        send(mk_head(4'h2, 4'h0, 3'b010, 8'h01, 8'd0, 32'h3000));
        send(mk_tail(8'h01, 32'h0));
        chk("rd_type", axi_type, 3'b010);
        chk("rd_no_data", empty_vc, 8'hFF);

        // Fill VC0 to capacity; the 17th flit waits for a pop.
        send(mk_head(4'h1, 4'h0, 3'b100, 8'h01, 8'd16, 32'h4000));
        for (int i = 0; i < 17; i++) fd[i] = rand_data();
        for (int i = 0; i < 16; i++) send(fd[i]);
        chk("vc0_full_ready", flit_ready, 1'b0);
        fork
            begin
                send(fd[16]);
                send(mk_tail(8'h01, 32'h0));
            end
            begin
                repeat (4) begin @(negedge noc_clk); #2; chk("ready_low_full", flit_ready, 1'b0); end
                pop(0);
                chk("first_flit_out", data_out, fd[0]);
                repeat (3) @(posedge noc_clk);
                pop(0);
            end
        join
        while (mq[0].size() != 0) pop(0);
        chk("last_flit_out", data_out, fd[16]);

        // Foreign Dest_ID: consumed silently.
        send(mk_head(4'h4, 4'h3, 3'b100, 8'h02, 8'd1, 32'h5000));
        repeat (2) send(rand_data());
        send(mk_tail(8'h02, 32'h0));
        chk("drop_empty", empty_vc, 8'hFF);
        chk("drop_err", err_cnt, 8'h00);

        // Stray data in idle, then a two-hot ORDER.
        send(rand_data());
        send(mk_head(4'h4, 4'h0, 3'b100, 8'h06, 8'd1, 32'h6000));
        send(rand_data());
        send(mk_tail(8'h06, 32'h0));
        chk("err_two", err_cnt, 8'd2);
        chk("err_nothing_written", empty_vc, 8'hFF);

        // Busy blocks a head in idle.
        nsu_busy = 1'b1;
        @(negedge noc_clk); #1;
        flit_in = mk_head(4'h6, 4'h0, 3'b100, 8'h08, 8'd1, 32'h7000); flit_valid = 1'b1;
        repeat (3) begin @(negedge noc_clk); #1; chk("busy_ready", flit_ready, 1'b0); end
        flit_valid = 1'b0; nsu_busy = 1'b0;
        send(mk_head(4'h6, 4'h0, 3'b100, 8'h08, 8'd1, 32'h7000));
        send(rand_data());
        send(mk_tail(8'h08, 32'h7100));
        pop(3);

        // Error counter saturation.
        repeat (256) send(rand_data());
        chk("err_sat", err_cnt, 8'hFF);

        // Reset mid-packet, then a normal packet.
        send(mk_head(4'h7, 4'h0, 3'b001, 8'h20, 8'd3, 32'h8000));
        repeat (2) send(rand_data());
        do_reset();
        send(mk_head(4'h7, 4'h0, 3'b001, 8'h20, 8'd1, 32'h9000));
        repeat (2) send(rand_data());
        send(mk_tail(8'h20, 32'h9100));
        chk("post_rst_vc5", empty_vc, 8'hDF);
        repeat (2) pop(5);

        // Randomised packet traffic.
        abandoned = 0;
        for (int p = 0; p < 40; p++) begin
            int vc, nd;
            logic [7:0] ord;
            logic [3:0] dst;
            logic [2:0] typ;
            if (m_state == 0 && $urandom_range(0, 7) == 0) send(rand_data());
            if (m_state == 1 && mq[m_vc].size() >= 16) pop(m_vc);
            vc  = $urandom_range(0, 7);
            ord = 8'(1 << vc);
            if (!abandoned && $urandom_range(0, 7) == 0) ord = ord | 8'(1 << ((vc + 3) % 8));
            dst = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            typ = 3'($urandom_range(0, 7));
            nd  = (typ == 3'b010) ? 0 : $urandom_range(0, 5);
            while (mq[vc].size() + nd >= 16) pop(vc);
            send(mk_head(4'($urandom_range(0, 15)), dst, typ, ord, 8'($urandom_range(0, 255)), $urandom()));
            for (int i = 0; i < nd; i++) send(rand_data());
            abandoned = ($urandom_range(0, 9) == 0);
            if (!abandoned) send(mk_tail(8'(1 << $urandom_range(0, 7)), $urandom()));
            repeat ($urandom_range(0, 3)) pop($urandom_range(0, 7));
        end
        if (abandoned) send(mk_tail(8'h01, 32'h0));
        for (int k = 0; k < 8; k++) while (mq[k].size() != 0) pop(k);
        chk("final_empty", empty_vc, 8'hFF);
        chk("final_err", err_cnt, exp_err);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
